// File: rtl/simple_function_pkg.sv
// Shared types and helpers for the table-driven 3-input Boolean function block.
package simple_function_pkg;

   // Default table: y = (~b & ~c) | (a & ~b); bit[{a,b,c}] holds y.
   localparam logic [7:0] DEFAULT_TT = 8'b0011_0001;
   localparam int         SF_TT_W    = 8;

   typedef logic [2:0] sf_idx_t;

   function automatic sf_idx_t sf_pack(input logic a, input logic b, input logic c);
      return {a, b, c};
   endfunction

   // Plain indexed select, so an unknown index propagates X rather than a masked value.
   function automatic logic sf_eval(input logic [SF_TT_W-1:0] tt, input sf_idx_t idx);
      return tt[idx];
   endfunction

endpackage

// File: rtl/simple_function_lut.sv
// Pure combinational 8:1 truth-table lookup used by simple_function.
module simple_function_lut
   import simple_function_pkg::*;
#(
   parameter logic [SF_TT_W-1:0] TRUTH_TABLE = DEFAULT_TT
)(
   input  sf_idx_t idx,
   output logic    y
);

   assign y = sf_eval(TRUTH_TABLE, idx);

endmodule

// File: rtl/simple_function.sv
// Table-driven 3-input function with registered copy and saturating activity counter.
// Optional SIMPLE_FUNCTION_MINTERM_EN adds a one-hot minterm output and a consistency assertion.
module simple_function
   import simple_function_pkg::*;
#(
   parameter logic [SF_TT_W-1:0] TRUTH_TABLE = DEFAULT_TT,
   parameter int                 CNT_W       = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             y,
   output logic             y_q,
   output logic [CNT_W-1:0] y_count,
`ifdef SIMPLE_FUNCTION_MINTERM_EN
   output logic             count_sat,
   output logic [7:0]       minterm
`else
   output logic             count_sat
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Increment only when enabled, holding at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
      if (en && (cnt != CNT_MAX))
         return cnt + CNT_ONE;
      return cnt;
   endfunction

   sf_idx_t          idx_p0;
   logic             y_p0;
   logic             y_p1;
   logic [CNT_W-1:0] cnt_p1;

   // Stage p0: combinational lookup, valid even while reset is asserted.
   assign idx_p0 = sf_pack(a, b, c);

   simple_function_lut #(
      .TRUTH_TABLE (TRUTH_TABLE)
   ) u_lut (
      .idx (idx_p0),
      .y   (y_p0)
   );

   assign y = y_p0;

   // Stage p1: registered result and activity count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         y_p1   <= 1'b0;
         cnt_p1 <= '0;
      end else begin
         y_p1   <= y_p0;
         cnt_p1 <= sat_inc(cnt_p1, y_p0);
      end
   end

   assign y_q       = y_p1;
   assign y_count   = cnt_p1;
   assign count_sat = (cnt_p1 == CNT_MAX);

`ifdef SIMPLE_FUNCTION_MINTERM_EN
   assign minterm = 8'b0000_0001 << idx_p0;

   always_comb begin
      if (!$isunknown(idx_p0))
         assert (y_p0 == |(minterm & TRUTH_TABLE));
   end
`endif

endmodule

// File: tb/tb_simple_function.sv
// Directed bench for simple_function with a behavioural model checked every cycle.
module tb_simple_function;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        a = 1'b0, b = 1'b0, c = 1'b0;

   logic        y, y_q, count_sat;
   logic [15:0] y_count;
   logic        y2, y_q2, count_sat2;
   logic [1:0]  y_count2;
`ifdef SIMPLE_FUNCTION_MINTERM_EN
   logic [7:0]  minterm, minterm2;
`endif

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   simple_function #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
      .y(y), .y_q(y_q), .y_count(y_count),
`ifdef SIMPLE_FUNCTION_MINTERM_EN
      .count_sat(count_sat), .minterm(minterm)
`else
      .count_sat(count_sat)
`endif
   );

   simple_function #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
      .y(y2), .y_q(y_q2), .y_count(y_count2),
`ifdef SIMPLE_FUNCTION_MINTERM_EN
      .count_sat(count_sat2), .minterm(minterm2)
`else
      .count_sat(count_sat2)
`endif
   );

   // The Boolean equation itself, independent of any table.
   function automatic logic f_ref(input logic aa, input logic bb, input logic cc);
      return (~bb & ~cc) | (aa & ~bb);
   endfunction

   logic m_yq  = 1'b0;
   int   m_cnt = 0;
   int   m_cnt2 = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_yq   <= 1'b0;
         m_cnt  <= 0;
         m_cnt2 <= 0;
      end else begin
         m_yq <= f_ref(a, b, c);
         if (f_ref(a, b, c)) begin
            m_cnt  <= (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
            m_cnt2 <= (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("cmp_y",      32'(y),          32'(f_ref(a, b, c)));
         chk("cmp_y_q",    32'(y_q),        32'(m_yq));
         chk("cmp_cnt",    32'(y_count),    32'(m_cnt));
         chk("cmp_sat",    32'(count_sat),  32'(m_cnt == 65535));
         chk("cmp_y2",     32'(y2),         32'(f_ref(a, b, c)));
         chk("cmp_y_q2",   32'(y_q2),       32'(m_yq));
         chk("cmp_cnt2",   32'(y_count2),   32'(m_cnt2));
         chk("cmp_sat2",   32'(count_sat2), 32'(m_cnt2 == 3));
`ifdef SIMPLE_FUNCTION_MINTERM_EN
         chk("cmp_minterm", 32'(minterm),   32'(8'b1 << {a, b, c}));
`endif
      end
   end

   logic exp_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_y_q",   32'(y_q),        32'd0);
      chk("rst_cnt",   32'(y_count),    32'd0);
      chk("rst_sat",   32'(count_sat),  32'd0);
      chk("rst_cnt2",  32'(y_count2),   32'd0);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         {a, b, c} = 3'(i);
         #4;
         chk("sweep_y", 32'(y), 32'(exp_tab[i]));
         @(negedge clk);
      end

      {a, b, c} = 3'b100;
      @(posedge clk); #1;
      chk("reg_y_q_hi", 32'(y_q), 32'd1);
      @(negedge clk);
      {a, b, c} = 3'b110;
      @(posedge clk); #1;
      chk("reg_y_q_lo", 32'(y_q), 32'd0);

      @(negedge clk);
      {a, b, c} = 3'b001;
      #2;
      chk("zl_y_lo", 32'(y), 32'd0);
      {a, b, c} = 3'b000;
      #1;
      chk("zl_y_hi", 32'(y), 32'd1);

      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      {a, b, c} = 3'b011;
      repeat (3) @(posedge clk);
      #1;
      chk("cnt_five", 32'(y_count), 32'd5);
      chk("cnt_y_q",  32'(y_q),     32'd0);

      @(negedge clk);
      reset = 1'b0;
      {a, b, c} = 3'b100;
      @(posedge clk); #1;
      chk("mid_rst_y_q", 32'(y_q),       32'd0);
      chk("mid_rst_cnt", 32'(y_count),   32'd0);
      chk("mid_rst_sat", 32'(count_sat), 32'd0);
      chk("mid_rst_y",   32'(y),         32'd1);
      {a, b, c} = 3'b010;
      #1;
      chk("mid_rst_y_follow", 32'(y), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      {a, b, c} = 3'b101;
      repeat (2) @(posedge clk);
      #1;
      chk("sat_cnt2_two", 32'(y_count2),   32'd2);
      chk("sat_flag_off", 32'(count_sat2), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("sat_cnt2_max", 32'(y_count2),   32'd3);
      chk("sat_flag_on",  32'(count_sat2), 32'd1);
      chk("sat_wide_cnt", 32'(y_count),    32'd6);
      chk("sat_wide_off", 32'(count_sat),  32'd0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
